// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder
//
// Sequential priority encoder. It captures a WIDTH-bit request vector and
// streams out the index of every set bit, highest index first, with one index
// per accepted beat on a valid/ready handshake. An all-zero vector produces a
// single marker beat: idx=EMPTY_CODE, last=1, empty=1.
//
// Parameters:
//   WIDTH      request vector width (2..128)
//   IDX_W      index width, derived from WIDTH (do not override)
//   EMPTY_CODE code reported while idle and for the empty-vector beat (>= WIDTH)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          clock enable; when low, all state holds and handshakes are ignored
//   req_vec      request bits, captured when load is accepted
//   load         capture request; accepted only while load_ready=1
//   load_ready   high in IDLE
//   idx          current index, zero-extended to 8 bits (EMPTY_CODE when idle or empty)
//   idx_valid    beat valid
//   idx_ready    sink accepts the beat
//   last         current beat is the final one of the vector
//   empty        current beat is the all-zero marker
//   abort        drop all pending work (EMIT only)
//   busy         not IDLE
//   remaining    beats left including the current one; present only when
//                PRIO_SCAN_COUNT_EN is defined
//
// Optional feature macro: PRIO_SCAN_COUNT_EN adds the remaining-beats counter.
//
// Every output is decoded from registers only, so there is no combinational
// path from any input to any output.

module prio_scan_encoder #(
  parameter int         WIDTH      = 16,
  parameter int         IDX_W      = $clog2(WIDTH),
  parameter logic [7:0] EMPTY_CODE = 8'hF0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] req_vec,
  input  logic             load,
  output logic             load_ready,
  output logic [7:0]       idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             last,
  output logic             empty,
  input  logic             abort,
  output logic             busy
`ifdef PRIO_SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   remaining
`endif
);

  localparam int               PADW = 8 - IDX_W;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pending_q;  // bits not yet reported
  logic             empty_q;    // the captured vector was all-zero

  logic [IDX_W-1:0] hi_idx;
  logic             one_left;
  logic             accept;
  logic [WIDTH-1:0] pending_d;

  // Highest set bit of pending. The ascending scan lets the last hit win.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) hi_idx = IDX_W'(i);
    end
  end

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign one_left  = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);

  // In EMIT idx_valid is always 1, so an accept is just ready seen in EMIT.
  assign accept    = (state_q == EMIT) && idx_ready;
  assign pending_d = pending_q & ~(ONE << hi_idx);

`ifdef PRIO_SCAN_COUNT_EN
  logic [IDX_W:0] cnt_q;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + (IDX_W+1)'(v[i]);
    return c;
  endfunction
`endif

  // Single state machine. Abort takes priority over an accept in the same
  // cycle. ena=0 freezes everything, including handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      empty_q   <= 1'b0;
`ifdef PRIO_SCAN_COUNT_EN
      cnt_q     <= '0;
`endif
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          // An abort in IDLE has no effect, so it does not block a load.
          if (load) begin
            state_q   <= EMIT;
            pending_q <= req_vec;
            empty_q   <= (req_vec == '0);
`ifdef PRIO_SCAN_COUNT_EN
            // The empty vector still costs one marker beat.
            cnt_q     <= (req_vec == '0) ? (IDX_W+1)'(1) : popcount(req_vec);
`endif
          end
        end
        EMIT: begin
          if (abort) begin
            state_q   <= IDLE;
            pending_q <= '0;
            empty_q   <= 1'b0;
`ifdef PRIO_SCAN_COUNT_EN
            cnt_q     <= '0;
`endif
          end else if (accept) begin
            // For the empty marker, pending is already zero and stays zero.
            pending_q <= pending_d;
`ifdef PRIO_SCAN_COUNT_EN
            cnt_q     <= cnt_q - (IDX_W+1)'(1);
`endif
            if (empty_q || one_left) begin
              state_q <= IDLE;
              empty_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode (registers only)
  always_comb begin
    load_ready = 1'b1;
    busy       = 1'b0;
    idx_valid  = 1'b0;
    idx        = EMPTY_CODE;
    last       = 1'b0;
    empty      = 1'b0;
    if (state_q == EMIT) begin
      load_ready = 1'b0;
      busy       = 1'b1;
      idx_valid  = 1'b1;
      if (empty_q) begin
        last  = 1'b1;
        empty = 1'b1;
      end else begin
        idx  = {{PADW{1'b0}}, hi_idx};
        last = one_left;
      end
    end
  end

`ifdef PRIO_SCAN_COUNT_EN
  // The counter reaches 0 on the final accept, so it reads 0 in IDLE.
  assign remaining = cnt_q;
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Testbench for prio_scan_encoder (WIDTH=16).
// The reference model holds the expected beats of the current vector in a
// queue: set-bit indices in descending order, or a single -1 for the
// empty-vector marker. An empty queue means the DUT is idle. A compare process
// checks every DUT output against this model on each falling edge. Directed
// scenarios also check hand-computed literals, followed by a randomized phase.
module tb_prio_scan_encoder;
  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0, rst_n = 1'b0, ena = 1'b0, load = 1'b0;
  logic             idx_ready = 1'b0, abort = 1'b0;
  logic [WIDTH-1:0] req_vec = '0;
  logic             load_ready, idx_valid, last, empty, busy;
  logic [7:0]       idx;
`ifdef PRIO_SCAN_COUNT_EN
  logic [IDX_W:0]   remaining;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prio_scan_encoder #(.WIDTH(WIDTH), .EMPTY_CODE(8'hF0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_vec(req_vec), .load(load),
    .load_ready(load_ready), .idx(idx), .idx_valid(idx_valid),
    .idx_ready(idx_ready), .last(last), .empty(empty), .abort(abort),
    .busy(busy)
`ifdef PRIO_SCAN_COUNT_EN
    , .remaining(remaining)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of beats still to be delivered
  int q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (ena) begin
      if (q.size() == 0) begin
        if (load) begin
          for (int i = WIDTH-1; i >= 0; i--) if (req_vec[i]) q.push_back(i);
          if (q.size() == 0) q.push_back(-1);
        end
      end else if (abort) q.delete();
      else if (idx_ready) void'(q.pop_front());
    end
  end

  // Compare process: each DUT output against the model on every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() == 0) begin
        chk("m_idx", idx, 8'hF0);
        chk("m_valid", idx_valid, 0);
        chk("m_ldrdy", load_ready, 1);
        chk("m_busy", busy, 0);
        chk("m_last", last, 0);
        chk("m_empty", empty, 0);
`ifdef PRIO_SCAN_COUNT_EN
        chk("m_remaining", remaining, 0);
`endif
      end else begin
        chk("m_idx", idx, (q[0] < 0) ? 8'hF0 : q[0]);
        chk("m_valid", idx_valid, 1);
        chk("m_ldrdy", load_ready, 0);
        chk("m_busy", busy, 1);
        chk("m_last", last, q.size() == 1);
        chk("m_empty", empty, q[0] < 0);
`ifdef PRIO_SCAN_COUNT_EN
        chk("m_remaining", remaining, q.size());
`endif
      end
    end
  end

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_valid", idx_valid, 0);
    chk("rst_idx", idx, 8'hF0);
    chk("rst_ldrdy", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_last", last, 0);
    chk("rst_empty", empty, 0);
    #10 rst_n = 1'b1;
    ena = 1'b1;
    step();

    // 8001: two beats, then one idle cycle
    req_vec = 16'h8001; load = 1'b1; idx_ready = 1'b1;
    step(); load = 1'b0;
    chk("8001_b0_idx", idx, 15); chk("8001_b0_last", last, 0); chk("8001_b0_v", idx_valid, 1);
    step();
    chk("8001_b1_idx", idx, 0);  chk("8001_b1_last", last, 1);
    step();
    chk("8001_ldrdy", load_ready, 1); chk("8001_v", idx_valid, 0);

    // Empty vector: a single marker beat
    req_vec = 16'h0000; load = 1'b1;
    step(); load = 1'b0;
    chk("e_idx", idx, 8'hF0); chk("e_last", last, 1); chk("e_empty", empty, 1); chk("e_v", idx_valid, 1);
    step();
    chk("e_idle", busy, 0);

    // 0A00 under backpressure, with a load pulsed during emission
    req_vec = 16'h0A00; load = 1'b1; idx_ready = 1'b0;
    step(); load = 1'b0;
    chk("bp_idx0", idx, 11);
    step(); req_vec = 16'hFFFF; load = 1'b1;
    chk("bp_idx1", idx, 11); chk("bp_last1", last, 0);
    step(); load = 1'b0; idx_ready = 1'b1;
    chk("bp_idx2", idx, 11); chk("bp_ldrdy", load_ready, 0);
    step();
    chk("bp_idx3", idx, 9); chk("bp_last3", last, 1);
    step();
    chk("bp_idle", load_ready, 1);

    // Abort after two beats of FFFF; the abort wins over the accept
    req_vec = 16'hFFFF; load = 1'b1;
    step(); load = 1'b0;
    chk("ab_15", idx, 15);
    step();
    chk("ab_14", idx, 14); abort = 1'b1;
    step(); abort = 1'b0;
    chk("ab_v", idx_valid, 0); chk("ab_ldrdy", load_ready, 1);

    // ena low freezes the stream
    load = 1'b1;
    step(); load = 1'b0; ena = 1'b0;
    chk("en_15a", idx, 15);
    step(); chk("en_15b", idx, 15);
    step(); chk("en_15c", idx, 15); ena = 1'b1;
    step(); chk("en_14", idx, 14);
    abort = 1'b1;
    step(); abort = 1'b0;

`ifdef PRIO_SCAN_COUNT_EN
    begin
      int exp_i[6] = '{7, 6, 5, 4, 1, 0};
      req_vec = 16'h00F3; load = 1'b1;
      step(); load = 1'b0;
      for (int k = 0; k < 6; k++) begin
        chk("cnt_idx", idx, exp_i[k]);
        chk("cnt_rem", remaining, 6 - k);
        step();
      end
      chk("cnt_idle", remaining, 0);
    end
`endif

    // Reset in the middle of a stream
    req_vec = 16'hFFFF; load = 1'b1; idx_ready = 1'b1;
    step(); load = 1'b0;
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", idx_valid, 0); chk("mr_idx", idx, 8'hF0);
    chk("mr_busy", busy, 0); chk("mr_ldrdy", load_ready, 1);
    #1 rst_n = 1'b1;
    step();

    // Randomized traffic checked by the compare process
    for (int c = 0; c < 3000; c++) begin
      ena       = ($urandom_range(0, 9) != 0);
      load      = $urandom_range(0, 1);
      idx_ready = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: req_vec = '0;
        1: req_vec = WIDTH'(1) << $urandom_range(0, WIDTH-1);
        2: req_vec = WIDTH'($urandom);
        default: req_vec = WIDTH'($urandom) & WIDTH'($urandom);
      endcase
      step();
    end
    load = 1'b0; abort = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
